// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  // Default operand width in bits (legal range 2..32).
  localparam int unsigned DEFAULT_WIDTH = 8;

  // Controller states: accept a request, shift WIDTH bits through the cell,
  // then spend one cycle collecting the last registered sum bit and carry.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage : serial_add_pkg

// File: rtl/fa_cell.sv
// Registered 1-bit full adder. Pure datapath: it adds whatever it is fed
// every cycle, and the controller decides which of its outputs to keep.
module fa_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Register the full-adder sum and carry every cycle, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= 1'b0;
      cout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge; blocking ones would make ordering matter.
      sum  <= a ^ b ^ cin;
      cout <= (a & b) | (a & cin) | (b & cin);
    end
  end

endmodule : fa_cell

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: computes {cout,sum} = a + b + cin one bit per
// cycle, LSB first, through a single registered fa_cell. The cell output for
// bit k is registered on E(k+1) and copied into sum[k] on E(k+2), so the
// result is complete, and done pulses, WIDTH+1 edges after the accepting edge.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // The counter reaches WIDTH (in DRAIN), so it needs room for that value.
  localparam int unsigned     KW     = $clog2(WIDTH + 1);
  localparam logic [KW-1:0]   K_ONE  = KW'(1);
  localparam logic [KW-1:0]   K_LAST = KW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic             cell_a, cell_b, cell_cin;
  logic             cell_sum, cell_cout;
  logic             capture;
  logic [KW-1:0]    cap_idx;

  fa_cell u_fa_cell (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (cell_a),
    .b     (cell_b),
    .cin   (cell_cin),
    .sum   (cell_sum),
    .cout  (cell_cout)
  );

  // The cell holds bit k-1 whenever k>=1 in RUN, and the final bit in DRAIN
  // (where k has reached WIDTH), so the capture index is always k-1.
  assign capture = ((state_q == RUN) && (k_q != '0)) || (state_q == DRAIN);
  assign cap_idx = k_q - K_ONE;

  // Next-state, operand shifting, cell feed and result capture.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
    cell_a   = 1'b0;
    cell_b   = 1'b0;
    cell_cin = 1'b0;

    // Overwrite only the bit being captured; the others keep their value.
    if (capture) begin
      sum_d = (sum_q & ~(ONE_W << cap_idx)) | (WIDTH'(cell_sum) << cap_idx);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          cin_d   = cin;
          k_d     = '0;
        end
      end
      RUN: begin
        // Operands shift right so bit k always sits at position 0.
        cell_a   = a_q[0];
        cell_b   = b_q[0];
        cell_cin = (k_q == '0) ? cin_q : cell_cout;
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        k_d      = k_q + K_ONE;
        if (k_q == K_LAST) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        cout_d  = cell_cout;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, operand and result registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand copies are a handful of flops, so they are reset
      // like everything else; a real memory array would be left unreset.
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8) plus a reference-checked sweep.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_pass   = 0;

  // Result expected to be held on the outputs before the next capture.
  logic [W-1:0] hold_sum  = '0;
  logic         hold_cout = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Starts one addition from the current (non-edge) point, scrambles the
  // operand inputs after the accepting edge, optionally injects a competing
  // start request, and returns positioned in the done cycle.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tci, input int inject_at);
    logic [W:0] ref_v;
    int lat;
    ref_v = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tci};
    a = ta; b = tb; cin = tci; start = 1'b1;
    @(posedge clk); #1;                       // E0
    start = 1'b0;
    check("busy_e0", busy, 1);
    check("hold_sum_e0", sum, hold_sum);
    check("hold_cout_e0", cout, hold_cout);
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 0;
    while (lat < 20) begin
      if (lat == inject_at) begin
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
      end
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
      if (done) break;
      check("busy_run", busy, 1);
    end
    check("latency", lat, W + 1);
    check("busy_at_done", busy, 0);
    check("result", {cout, sum}, ref_v);
    hold_sum  = ref_v[W-1:0];
    hold_cout = ref_v[W];
  endtask

  task automatic step_check_done_low(input string tag);
    @(posedge clk); #1;
    check(tag, done, 0);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // FF + 01 + 0 -> 0x100
    do_op(8'hFF, 8'h01, 1'b0, -1);
    step_check_done_low("done_one_cycle_a");

    // A5 + 5A + 1 -> 0x100
    do_op(8'hA5, 8'h5A, 1'b1, -1);
    step_check_done_low("done_one_cycle_b");

    // Back-to-back: second start is driven during the first done cycle.
    do_op(8'h12, 8'h34, 1'b0, -1);
    do_op(8'h80, 8'h80, 1'b0, -1);
    step_check_done_low("done_one_cycle_c");

    // Competing start sampled at E3 must be ignored.
    do_op(8'h3C, 8'h0F, 1'b0, 2);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("ignored_start_pulses", pulses, 0);
    check("ignored_start_busy", busy, 0);
    check("ignored_start_sum", sum, 8'h4B);
    check("ignored_start_cout", cout, 0);

    // Reset between E4 and E5 aborts the operation.
    a = 8'h77; b = 8'h11; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;                       // E0
    start = 1'b0;
    repeat (4) @(posedge clk);                // E4
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    hold_sum = '0; hold_cout = 1'b0;
    do_op(8'h01, 8'h01, 1'b1, -1);
    check("post_reset_sum", sum, 8'h03);
    check("post_reset_cout", cout, 0);

    // Sweep against the bench's own a+b+cin reference, back-to-back.
    for (int i = 0; i < 1000; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), -1);
    end
    step_check_done_low("done_one_cycle_d");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_add_ctrl

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 2..32.
REQ-002 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port start, input, 1: request to begin one addition; sampled only in IDLE.
REQ-005 Port a, input, WIDTH: operand A; sampled on the accepting edge only.
REQ-006 Port b, input, WIDTH: operand B; sampled on the accepting edge only.
REQ-007 Port cin, input, 1: carry-in; sampled on the accepting edge only.
REQ-008 Port busy, output, 1: high while an addition is in progress.
REQ-009 Port done, output, 1: one-cycle pulse; sum and cout are valid in this cycle.
REQ-010 Port sum, output, WIDTH: result bits, LSB first assembled.
REQ-011 Port cout, output, 1: final carry-out.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin bit-serially, using one registered 1-bit full-adder cell, one bit per cycle, LSB first.
REQ-013 States SHALL be IDLE, RUN and DRAIN.
- IDLE -> RUN when start=1 (the accepting edge, E0).
- RUN -> DRAIN after WIDTH cycles.
- DRAIN -> IDLE after 1 cycle.
REQ-014 On E0 the block SHALL latch a, b and cin into internal registers, clear the bit counter k to 0, and set busy=1.
REQ-015 In RUN cycle k, the cell inputs SHALL be a_r[k] and b_r[k]; the carry input SHALL be cin_r when k=0, else the cell's registered cout.
REQ-016 The cell's registered sum for bit k SHALL be captured into sum bit k on edge E(k+2), for k = 0..WIDTH-1.
- The cell's registered cout SHALL be captured into cout on edge E(WIDTH+1).
REQ-017 On edge E(WIDTH+1), state SHALL return to IDLE, busy SHALL fall and done SHALL rise.
- done SHALL be high for exactly one cycle.
- Total latency is WIDTH+1 edges from E0 to done.
REQ-018 sum and cout SHALL hold their last values from done until the next accepting edge.
- Behaviour when a new addition starts: the outputs SHALL NOT be cleared on E0; each bit is overwritten only when it is captured.
REQ-019 Any start received while busy=1 SHALL be ignored; no queuing.
REQ-020 A start in the same cycle done=1 SHALL be accepted, since state is IDLE; this gives back-to-back operation with a period of WIDTH+1 cycles.
REQ-021 Changes on a, b or cin after E0 SHALL NOT affect the in-flight result.
REQ-022 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during an operation.

Reset
REQ-023 rst_n=0 SHALL force the following immediately, independent of clk:
- state=IDLE, busy=0, done=0, sum=0, cout=0, k=0, operand registers=0;
- the cell's sum and cout registers = 0.
REQ-024 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL be produced for it.
REQ-025 After rst_n deasserts, the first start SHALL be accepted on the first posedge at which it is sampled high.

Structure
REQ-026 Package serial_add_pkg SHALL hold:
- the state enum type (IDLE, RUN, DRAIN);
- the default WIDTH constant.
REQ-027 The registered 1-bit adder cell SHALL be a sub-module named fa_cell.
- Ports: clk, rst_n, a, b, cin, sum, cout.
- Outputs registered, with asynchronous clear.
REQ-028 The controller (FSM, counter, operand and result registers) SHALL be in serial_add_ctrl; the cell SHALL hold no control logic.

Verification
REQ-029 WIDTH=8, a=8'hFF, b=8'h01, cin=0, start at E0 -> done high after E9 only; sum=8'h00, cout=1.
REQ-030 WIDTH=8, a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1; busy high from E0 through E8, low after E9.
REQ-031 Back-to-back: 8'h12+8'h34+0, then start held high in the done cycle with 8'h80+8'h80+0 -> sums 8'h46/cout 0, then 8'h00/cout 1; done pulses 9 cycles apart.
REQ-032 During an operation, pulse start with different operands at E3 -> ignored; the first result is unchanged and there is exactly one done pulse.
REQ-033 Assert rst_n=0 between E4 and E5 of an operation -> all outputs go to 0 immediately with no done pulse; a new 8'h01+8'h01+1 then completes with sum=8'h03, cout=0.
REQ-034 Random regression of 1000 operand pairs plus cin, with operands changed after E0 -> every {cout,sum} equals the reference a+b+cin.
